// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage data access engine; single-outstanding req/ack bus, load extract, MEM/WB regs.
// Latency: non-memory op 1 cycle; memory op 2 cycles minimum (entry edge + ack edge).
// Backpressure: mem_stall freezes upstream stages from the entry cycle until the dbus_ack cycle.
//
// Ports:
//   CLK, rst_n                      clock, async active-low reset
//   ex_mem_*, store_to_mem_I,       EX/MEM register outputs (address, rs2, enables, funct3,
//   MEM_*_En_I, funct3_I,           rd and write-back controls)
//   Reg_Wr_En_I, Src_to_Reg_I
//   dbus_req/we/addr/wdata/be       data bus request, held stable until dbus_ack
//   dbus_ack, dbus_rdata            bus completion; rdata valid with ack
//   mem_stall                       pipeline freeze, combinational
//   load_data_O, alu_result_O,      MEM/WB registers
//   mem_wb_rd, Reg_Wr_En_O, Src_to_Reg_O
//   misaligned_O                    one-cycle pulse when a misaligned access is dropped
module mem_access_unit #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            rst_n,
   input  logic            ex_mem_valid,
   input  logic [XLEN-1:0] ex_mem_addr,
   input  logic [XLEN-1:0] store_to_mem_I,
   input  logic            MEM_Wr_En_I,
   input  logic            MEM_Rd_En_I,
   input  logic [2:0]      funct3_I,
   input  logic [4:0]      ex_mem_rd,
   input  logic            Reg_Wr_En_I,
   input  logic [1:0]      Src_to_Reg_I,
   output logic            dbus_req,
   output logic            dbus_we,
   output logic [XLEN-1:0] dbus_addr,
   output logic [XLEN-1:0] dbus_wdata,
   output logic [3:0]      dbus_be,
   input  logic            dbus_ack,
   input  logic [XLEN-1:0] dbus_rdata,
   output logic            mem_stall,
   output logic [XLEN-1:0] load_data_O,
   output logic [XLEN-1:0] alu_result_O,
   output logic [4:0]      mem_wb_rd,
   output logic            Reg_Wr_En_O,
   output logic [1:0]      Src_to_Reg_O,
   output logic            misaligned_O
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]      state;
   logic [XLEN-1:0] cap_addr;
   logic [2:0]      cap_f3;
   logic [4:0]      cap_rd;
   logic            cap_rwe;
   logic [1:0]      cap_src;

   logic            access;
   logic            misaligned;
   logic            aligned_acc;
   logic [3:0]      be_n;
   logic [XLEN-1:0] wdata_n;
   logic [7:0]      lane8;
   logic [15:0]     lane16;
   logic [XLEN-1:0] ld_ext;

   assign access      = ex_mem_valid & (MEM_Wr_En_I | MEM_Rd_En_I);
   // funct3[1:0] carries the size for both signed and unsigned loads
   assign misaligned  = access & (((funct3_I[1:0] == 2'b01) & ex_mem_addr[0]) |
                                  ((funct3_I[1:0] == 2'b10) & (ex_mem_addr[1:0] != 2'b00)));
   assign aligned_acc = access & ~misaligned;

   // In BUSY the stall releases in the ack cycle so the pipeline advances on that edge
   assign mem_stall = (state == IDLE) ? aligned_acc : ~dbus_ack;
   assign dbus_addr = {cap_addr[XLEN-1:2], 2'b00};

   always_comb begin
      be_n    = 4'b1111;
      wdata_n = store_to_mem_I;
      case (funct3_I[1:0])
         2'b00: begin
            be_n    = 4'b0001 << ex_mem_addr[1:0];
            wdata_n = {4{store_to_mem_I[7:0]}};
         end
         2'b01: begin
            be_n    = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{store_to_mem_I[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      lane8 = dbus_rdata[7:0];
      case (cap_addr[1:0])
         2'b01:   lane8 = dbus_rdata[15:8];
         2'b10:   lane8 = dbus_rdata[23:16];
         2'b11:   lane8 = dbus_rdata[31:24];
         default: ;
      endcase
      lane16 = cap_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
      case (cap_f3)
         3'b000:  ld_ext = {{24{lane8[7]}}, lane8};
         3'b100:  ld_ext = {24'b0, lane8};
         3'b001:  ld_ext = {{16{lane16[15]}}, lane16};
         3'b101:  ld_ext = {16'b0, lane16};
         default: ld_ext = dbus_rdata;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         dbus_req     <= 1'b0;
         dbus_we      <= 1'b0;
         dbus_wdata   <= '0;
         dbus_be      <= 4'b0;
         cap_addr     <= '0;
         cap_f3       <= 3'b0;
         cap_rd       <= 5'b0;
         cap_rwe      <= 1'b0;
         cap_src      <= 2'b0;
         load_data_O  <= '0;
         alu_result_O <= '0;
         mem_wb_rd    <= 5'b0;
         Reg_Wr_En_O  <= 1'b0;
         Src_to_Reg_O <= 2'b0;
         misaligned_O <= 1'b0;
      end else begin
         misaligned_O <= 1'b0;
         case (state)
            IDLE: begin
               if (aligned_acc) begin
                  // Snapshot everything the access needs; inputs are don't-care while BUSY
                  dbus_req    <= 1'b1;
                  dbus_we     <= MEM_Wr_En_I;
                  dbus_wdata  <= wdata_n;
                  dbus_be     <= be_n;
                  cap_addr    <= ex_mem_addr;
                  cap_f3      <= funct3_I;
                  cap_rd      <= ex_mem_rd;
                  cap_rwe     <= Reg_Wr_En_I;
                  cap_src     <= Src_to_Reg_I;
                  Reg_Wr_En_O <= 1'b0;
                  state       <= BUSY;
               end else if (misaligned) begin
                  misaligned_O <= 1'b1;
                  Reg_Wr_En_O  <= 1'b0;
               end else begin
                  mem_wb_rd    <= ex_mem_rd;
                  Reg_Wr_En_O  <= Reg_Wr_En_I & ex_mem_valid;
                  Src_to_Reg_O <= Src_to_Reg_I;
                  alu_result_O <= ex_mem_addr;
               end
            end
            BUSY: begin
               if (dbus_ack) begin
                  dbus_req     <= 1'b0;
                  mem_wb_rd    <= cap_rd;
                  Reg_Wr_En_O  <= cap_rwe;
                  Src_to_Reg_O <= cap_src;
                  load_data_O  <= ld_ext;
                  alu_result_O <= cap_addr;
                  state        <= IDLE;
               end else begin
                  Reg_Wr_En_O <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        rst_n;
   logic        ex_mem_valid;
   logic [31:0] ex_mem_addr;
   logic [31:0] store_to_mem_I;
   logic        MEM_Wr_En_I;
   logic        MEM_Rd_En_I;
   logic [2:0]  funct3_I;
   logic [4:0]  ex_mem_rd;
   logic        Reg_Wr_En_I;
   logic [1:0]  Src_to_Reg_I;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_be;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;
   logic        mem_stall;
   logic [31:0] load_data_O;
   logic [31:0] alu_result_O;
   logic [4:0]  mem_wb_rd;
   logic        Reg_Wr_En_O;
   logic [1:0]  Src_to_Reg_O;
   logic        misaligned_O;

   int total  = 0;
   int passed = 0;

   mem_access_unit #(.XLEN(32)) dut (
      .CLK(CLK), .rst_n(rst_n),
      .ex_mem_valid(ex_mem_valid), .ex_mem_addr(ex_mem_addr), .store_to_mem_I(store_to_mem_I),
      .MEM_Wr_En_I(MEM_Wr_En_I), .MEM_Rd_En_I(MEM_Rd_En_I), .funct3_I(funct3_I),
      .ex_mem_rd(ex_mem_rd), .Reg_Wr_En_I(Reg_Wr_En_I), .Src_to_Reg_I(Src_to_Reg_I),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_be(dbus_be), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
      .mem_stall(mem_stall), .load_data_O(load_data_O), .alu_result_O(alu_result_O),
      .mem_wb_rd(mem_wb_rd), .Reg_Wr_En_O(Reg_Wr_En_O), .Src_to_Reg_O(Src_to_Reg_O),
      .misaligned_O(misaligned_O)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model: access size arithmetic ----------------
   function automatic int size_of(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int s = size_of(f3);
      return 4'(((1 << s) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      int s = size_of(f3);
      longint unit = longint'(rs2) & ((64'd1 << (8 * s)) - 1);
      logic [31:0] r = 0;
      for (int i = 0; i < 4; i += s) r |= 32'(unit << (8 * i));
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
      int s = size_of(f3);
      longint mask = (64'd1 << (8 * s)) - 1;
      longint v = (longint'(rd) >> (8 * (a % 4))) & mask;
      if (s < 4 && f3[2] == 1'b0 && v[8 * s - 1]) v = v | ~mask;
      return 32'(v);
   endfunction

   task automatic idle_inputs();
      ex_mem_valid = 0; MEM_Wr_En_I = 0; MEM_Rd_En_I = 0; Reg_Wr_En_I = 0; dbus_ack = 0;
   endtask

   // kind: 0 = ALU op, 1 = load, 2 = store. Called and returns just after a rising edge.
   task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rdata, input int dly,
                         input logic rwe, input logic [4:0] rd, input logic [1:0] src);
      int  stalls;
      bit  acc = (kind != 0);
      bit  mis = acc && ((addr % size_of(f3)) != 0);
      ex_mem_valid = 1; ex_mem_addr = addr; store_to_mem_I = rs2;
      MEM_Wr_En_I = (kind == 2); MEM_Rd_En_I = (kind == 1); funct3_I = f3;
      ex_mem_rd = rd; Reg_Wr_En_I = rwe; Src_to_Reg_I = src;
      dbus_ack = 1'($urandom_range(1, 0));   // must be ignored while IDLE
      dbus_rdata = $urandom;
      @(negedge CLK);
      if (!acc || mis) begin
         check("stall_nonaccess", mem_stall, 0);
         @(posedge CLK); #1;
         idle_inputs();
         check("noreq", dbus_req, 0);
         check("misaligned_O", misaligned_O, mis);
         check("wb_en", Reg_Wr_En_O, mis ? 1'b0 : rwe);
         if (!mis) begin
            check("wb_rd", mem_wb_rd, rd);
            check("wb_src", Src_to_Reg_O, src);
            check("alu_result", alu_result_O, addr);
         end
         @(posedge CLK); #1;
         check("mis_pulse_end", misaligned_O, 0);
         check("wb_en_pulse", Reg_Wr_En_O, 0);
         return;
      end
      check("stall_entry", mem_stall, 1);
      stalls = 1;
      @(posedge CLK); #1;
      // Upstream values change freely during BUSY; the access must not notice
      ex_mem_addr = $urandom; store_to_mem_I = $urandom; funct3_I = 3'($urandom);
      ex_mem_rd = 5'($urandom); Src_to_Reg_I = 2'($urandom); Reg_Wr_En_I = 1'($urandom);
      for (int k = 0; k <= dly; k++) begin
         dbus_ack   = (k == dly);
         dbus_rdata = (k == dly) ? rdata : $urandom;
         @(negedge CLK);
         check("req", dbus_req, 1);
         check("we", dbus_we, kind == 2);
         check("addr", dbus_addr, addr & ~32'd3);
         check("be", dbus_be, m_be(f3, addr));
         if (kind == 2) check("wdata", dbus_wdata, m_wdata(f3, rs2));
         check("wb_bubble", Reg_Wr_En_O, 0);
         stalls += int'(mem_stall);
         @(posedge CLK); #1;
      end
      idle_inputs();
      check("stall_cycles", stalls, dly + 1);
      check("req_drop", dbus_req, 0);
      check("wb_en", Reg_Wr_En_O, rwe);
      check("wb_rd", mem_wb_rd, rd);
      check("wb_src", Src_to_Reg_O, src);
      if (kind == 1) check("load_data", load_data_O, m_load(f3, addr, rdata));
      @(posedge CLK); #1;
      check("wb_en_pulse", Reg_Wr_En_O, 0);
      check("req_gap", dbus_req, 0);
   endtask

   initial begin
      logic [2:0] ld_f3 [5];
      int kind;
      logic [2:0] f3;
      ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

      rst_n = 0;
      idle_inputs();
      ex_mem_addr = 0; store_to_mem_I = 0; funct3_I = 0; ex_mem_rd = 0;
      Src_to_Reg_I = 0; dbus_rdata = 0;
      #1;
      check("rst_req", dbus_req, 0);
      check("rst_we", dbus_we, 0);
      check("rst_addr", dbus_addr, 0);
      check("rst_wdata", dbus_wdata, 0);
      check("rst_be", dbus_be, 0);
      check("rst_stall", mem_stall, 0);
      check("rst_load", load_data_O, 0);
      check("rst_alu", alu_result_O, 0);
      check("rst_rd", mem_wb_rd, 0);
      check("rst_wben", Reg_Wr_En_O, 0);
      check("rst_src", Src_to_Reg_O, 0);
      check("rst_mis", misaligned_O, 0);
      repeat (2) @(posedge CLK);
      #1 rst_n = 1;
      @(posedge CLK); #1;

      // Directed scenarios
      run_op(0, 3'b010, 32'h1234, 0, 0, 0, 1, 5, 2'd1);                  // ALU op
      run_op(1, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 1, 7, 2'd2);        // LW
      run_op(1, 3'b000, 32'h103, 0, 32'h80FF_0011, 1, 1, 8, 2'd2);       // LB
      run_op(1, 3'b100, 32'h103, 0, 32'h80FF_0011, 0, 1, 9, 2'd2);       // LBU
      run_op(2, 3'b001, 32'h202, 32'h0000ABCD, 0, 3, 0, 0, 2'd0);        // SH, ack late
      run_op(1, 3'b010, 32'h101, 0, 0, 0, 1, 3, 2'd2);                   // misaligned LW

      // Reset while BUSY, then a stray ack after release
      ex_mem_valid = 1; MEM_Rd_En_I = 1; funct3_I = 3'b010; ex_mem_addr = 32'h40;
      ex_mem_rd = 4; Reg_Wr_En_I = 1; dbus_ack = 0;
      @(posedge CLK); #1;
      idle_inputs();
      check("busy_req", dbus_req, 1);
      rst_n = 0;
      #1;
      check("arst_req", dbus_req, 0);
      @(posedge CLK); #1;
      rst_n = 1;
      @(posedge CLK); #1;
      dbus_ack = 1; dbus_rdata = 32'h55AA55AA;
      @(negedge CLK);
      check("late_ack_stall", mem_stall, 0);
      @(posedge CLK); #1;
      dbus_ack = 0;
      check("late_ack_wben", Reg_Wr_En_O, 0);
      check("late_ack_load", load_data_O, 0);
      check("late_ack_req", dbus_req, 0);

      // Randomized mix against the model
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(2, 0);
         f3 = (kind == 2) ? 3'($urandom_range(2, 0)) : ld_f3[$urandom_range(4, 0)];
         run_op(kind, f3, $urandom, $urandom, $urandom, $urandom_range(3, 0),
                (kind == 2) ? 1'b0 : 1'($urandom), 5'($urandom), 2'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
